// File: rtl/chien_parallel_pkg.sv
// Shared GF(2^M) helpers and FSM encodings for the parallel Chien search.
package chien_parallel_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Code length N = 2^M - 1
  function automatic int gf_n(input int m);
    return (1 << m) - 1;
  endfunction

  // Number of SEARCH cycles needed to cover N exponents at P per cycle
  function automatic int search_cycles(input int m, input int p);
    return (gf_n(m) + p - 1) / p;
  endfunction

  // Primitive polynomial of the codebase, including the x^M term
  function automatic int prim_poly(input int m);
    case (m)
      3:       return 'h00b;
      4:       return 'h013;
      5:       return 'h025;
      6:       return 'h043;
      7:       return 'h089;
      8:       return 'h11d;
      9:       return 'h211;
      10:      return 'h409;
      default: return 'h013;
    endcase
  endfunction

  // alpha^k in GF(2^m), exponent reduced mod N; elaboration-time only
  function automatic int lpow(input int m, input int k);
    int v;
    v = 1;
    for (int i = 0; i < k % gf_n(m); i++) begin
      v = v << 1;
      if (((v >> m) & 1) != 0) v = v ^ prim_poly(m);
    end
    return v;
  endfunction

endpackage

// File: rtl/chien_parallel_term.sv
// One sigma term r_j: loaded with c_j, stepped by alpha^(j*P) per SEARCH cycle,
// and fanned out to P lanes as r_j * alpha^(j*l).
module chien_term
  import chien_parallel_pkg::*;
#(
  parameter int M = 4,
  parameter int P = 1,
  parameter int J = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  adv,
  input  logic [M-1:0]          coef,
  output logic [P-1:0][M-1:0]   prod
);

  localparam logic [M-1:0] POLY_LO = M'(prim_poly(M));
  localparam logic [M-1:0] STEP    = M'(lpow(M, J * P));

  // Multiply by a constant; with k fixed this folds into a pure XOR network
  function automatic logic [M-1:0] cmul(input logic [M-1:0] a, input logic [M-1:0] k);
    logic [M-1:0] acc, x;
    acc = '0;
    x   = a;
    for (int i = 0; i < M; i++) begin
      if (k[i]) acc = acc ^ x;
      x = {x[M-2:0], 1'b0} ^ (x[M-1] ? POLY_LO : '0);
    end
    return acc;
  endfunction

  logic [M-1:0] r_q, r_d;

  // Next term value: load coefficient, or advance by P exponents
  always_comb begin
    r_d = r_q;
    if (load)     r_d = coef;
    else if (adv) r_d = cmul(r_q, STEP);
  end

  // Term register
  always_ff @(posedge clk) begin
    if (reset) r_q <= '0;
    else       r_q <= r_d;
  end

  for (genvar l = 0; l < P; l++) begin : g_lane
    localparam logic [M-1:0] LC = M'(lpow(M, J * l));
    assign prod[l] = cmul(r_q, LC);
  end

endmodule

// File: rtl/chien_parallel.sv
// Parallel Chien search: tests P consecutive exponents of sigma(x) per clock,
// flags roots per lane, counts them and compares against the BM degree.
module chien_parallel
  import chien_parallel_pkg::*;
#(
  parameter int M = 4,
  parameter int T = 3,
  parameter int P = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [M*(T+1)-1:0]   sigma,
  input  logic [M-1:0]         deg,
  output logic                 ready,
  output logic                 err_valid,
  output logic [P-1:0]         err,
  output logic [M-1:0]         pos,
  output logic                 done,
  output logic [M-1:0]         count,
  output logic                 fail
);

  localparam int N = gf_n(M);

  logic [1:0]               state_q, state_d;
  logic [M-1:0]             pos_q, acc_q, deg_q;
  logic                     fail_q;
  logic                     load, adv, last;
  logic [M:0]               pos_next;
  logic [M-1:0]             pcnt, acc_next;
  logic [T:0][P-1:0][M-1:0] prod;
  logic [P-1:0][M-1:0]      lane_val;
  logic [P-1:0]             hit;

  assign load = (state_q == ST_IDLE) && start;
  assign adv  = (state_q == ST_SEARCH);

  for (genvar j = 0; j <= T; j++) begin : g_term
    chien_term #(.M(M), .P(P), .J(j)) u_term (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .adv   (adv),
      .coef  (sigma[j*M +: M]),
      .prod  (prod[j])
    );
  end

  // Lane value = XOR of all term products for that lane
  always_comb begin
    lane_val = '0;
    for (int l = 0; l < P; l++)
      for (int j = 0; j <= T; j++)
        lane_val[l] = lane_val[l] ^ prod[j][l];
  end

  // Root flags with tail mask (exponent must stay below N), plus popcount
  always_comb begin
    hit  = '0;
    pcnt = '0;
    for (int l = 0; l < P; l++) begin
      hit[l] = adv && (lane_val[l] == '0) &&
               (({1'b0, pos_q} + (M+1)'(l)) < (M+1)'(N));
      pcnt   = pcnt + M'(hit[l]);
    end
  end

  assign pos_next = {1'b0, pos_q} + (M+1)'(P);
  assign last     = pos_next >= (M+1)'(N);
  assign acc_next = acc_q + pcnt;

  // IDLE -> SEARCH on start, SEARCH -> DONE on last group, DONE lasts one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_SEARCH;
      ST_SEARCH: if (last)  state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Control, position and result registers; pos keeps the last evaluated group
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pos_q   <= '0;
      acc_q   <= '0;
      deg_q   <= '0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        pos_q  <= '0;
        acc_q  <= '0;
        deg_q  <= deg;
        fail_q <= 1'b0;
      end else if (adv) begin
        acc_q <= acc_next;
        if (last) fail_q <= (acc_next != deg_q);
        else      pos_q  <= pos_next[M-1:0];
      end
    end
  end

  assign ready     = (state_q == ST_IDLE);
  assign err_valid = adv;
  assign err       = hit;
  assign pos       = pos_q;
  assign done      = (state_q == ST_DONE);
  assign count     = acc_q;
  assign fail      = fail_q;

endmodule

// File: tb/tb_chien_parallel.sv
// Bench for chien_parallel: P=1 and P=4 instances, log-table GF model,
// per-beat scoreboard queues and result queues.
module tb_chien_parallel;

  logic        clk = 1'b0;
  logic        reset, start1, start4;
  logic [15:0] sigma;
  logic [3:0]  deg;

  logic       rdy1, v1, dn1, f1;
  logic [0:0] e1;
  logic [3:0] p1, c1;
  logic       rdy4, v4, dn4, f4;
  logic [3:0] e4, p4, c4;

  always #5 clk = ~clk;

  chien_parallel #(.M(4), .T(3), .P(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .sigma(sigma), .deg(deg),
    .ready(rdy1), .err_valid(v1), .err(e1), .pos(p1), .done(dn1),
    .count(c1), .fail(f1));

  chien_parallel #(.M(4), .T(3), .P(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .sigma(sigma), .deg(deg),
    .ready(rdy4), .err_valid(v4), .err(e4), .pos(p4), .done(dn4),
    .count(c4), .fail(f4));

  typedef struct { int pos; int err; int cyc; } beat_t;
  typedef struct { int cnt; int fl;  int cyc; } res_t;
  typedef struct { logic [15:0] sg; logic [3:0] dg; int cnt; int fl; } vec_t;

  beat_t bq[2][$];
  res_t  rq[2][$];
  int    errors = 0, checks = 0, cyc = 0;
  int    expv[15];
  int    lg[16];
  vec_t  tbl[5];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return expv[(lg[a] + lg[b]) % 15];
  endfunction

  function automatic int eval_sigma(input logic [15:0] sg, input int x);
    int v;
    v = 0;
    for (int j = 0; j < 4; j++)
      v = v ^ gmul(int'((sg >> (4*j)) & 16'hf), expv[(j*x) % 15]);
    return v;
  endfunction

  // Queue expected beats and result for a start accepted (skip+1) edges from now
  task automatic push(input int d, input int p, input logic [15:0] sg,
                      input int cnt, input int fl, input int skip);
    int base, k, e;
    beat_t b;
    res_t  r;
    base = cyc + 1 + skip;
    k = 0;
    for (int s = 0; s < 15; s += p) begin
      e = 0;
      for (int l = 0; l < p; l++)
        if (s + l < 15 && eval_sigma(sg, s + l) == 0) e = e | (1 << l);
      b.pos = s; b.err = e; b.cyc = base + k;
      bq[d].push_back(b);
      k++;
    end
    r.cnt = cnt; r.fl = fl; r.cyc = base + k;
    rq[d].push_back(r);
  endtask

  task automatic mon(input int d, input logic v, input int p, input int e,
                     input logic dn, input int c, input logic f);
    beat_t b;
    res_t  r;
    if (v) begin
      if (bq[d].size() == 0) begin
        errors++; checks++;
        $display("FAIL dut%0d_extra_beat: got pos %0d err %0d expected no beat", d, p, e);
      end else begin
        b = bq[d].pop_front();
        chk($sformatf("dut%0d_pos", d), p, b.pos);
        chk($sformatf("dut%0d_err@%0d", d, b.pos), e, b.err);
        chk($sformatf("dut%0d_beat_cycle", d), cyc, b.cyc);
      end
    end
    if (dn) begin
      if (rq[d].size() == 0) begin
        errors++; checks++;
        $display("FAIL dut%0d_extra_done: got done expected none", d);
      end else begin
        r = rq[d].pop_front();
        chk($sformatf("dut%0d_count", d), c, r.cnt);
        chk($sformatf("dut%0d_fail", d), int'(f), r.fl);
        chk($sformatf("dut%0d_done_cycle", d), cyc, r.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, v1, int'(p1), int'(e1), dn1, int'(c1), f1);
    mon(1, v4, int'(p4), int'(e4), dn4, int'(c4), f4);
  end

  // Called #1 after a posedge; start is sampled on the next edge
  task automatic kick(input bit a, input bit b, input logic [15:0] sg,
                      input logic [3:0] dg, input int cnt, input int fl);
    sigma = sg;
    deg   = dg;
    if (a) begin chk("dut0_ready", int'(rdy1), 1); push(0, 1, sg, cnt, fl, 0); start1 = 1'b1; end
    if (b) begin chk("dut1_ready", int'(rdy4), 1); push(1, 4, sg, cnt, fl, 0); start4 = 1'b1; end
    @(posedge clk); #1;
    start1 = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bq[0].size() + bq[1].size() + rq[0].size() + rq[1].size()) != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      errors++; checks++;
      $display("FAIL timeout: got %0d outstanding expected 0",
               bq[0].size() + bq[1].size() + rq[0].size() + rq[1].size());
      bq[0].delete(); bq[1].delete(); rq[0].delete(); rq[1].delete();
    end
  endtask

  initial begin
    int e, n;
    reset = 1'b1; start1 = 1'b0; start4 = 1'b0; sigma = '0; deg = '0;
    e = 1;
    for (int i = 0; i < 15; i++) begin
      expv[i] = e; lg[e] = i;
      e = e << 1;
      if ((e & 16) != 0) e = e ^ 19;
    end
    lg[0] = 0;
    tbl[0] = '{16'h0081, 4'd1, 1,  0};   // single root at exponent 12
    tbl[1] = '{16'h0081, 4'd2, 1,  1};   // degree mismatch
    tbl[2] = '{16'h0000, 4'd0, 15, 1};   // every position a root
    tbl[3] = '{16'h0001, 4'd0, 0,  0};   // constant, no roots
    tbl[4] = '{16'h0231, 4'd2, 2,  0};   // roots at exponents 0 and 14

    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready1", int'(rdy1), 1);  chk("rst_ready4", int'(rdy4), 1);
    chk("rst_valid1", int'(v1), 0);    chk("rst_valid4", int'(v4), 0);
    chk("rst_err1", int'(e1), 0);      chk("rst_err4", int'(e4), 0);
    chk("rst_pos1", int'(p1), 0);      chk("rst_pos4", int'(p4), 0);
    chk("rst_done1", int'(dn1), 0);    chk("rst_done4", int'(dn4), 0);
    chk("rst_count1", int'(c1), 0);    chk("rst_count4", int'(c4), 0);
    chk("rst_fail1", int'(f1), 0);     chk("rst_fail4", int'(f4), 0);
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      kick(1'b1, 1'b1, tbl[i].sg, tbl[i].dg, tbl[i].cnt, tbl[i].fl);
      wait_idle();
      chk($sformatf("hold_count1_v%0d", i), int'(c1), tbl[i].cnt);
      chk($sformatf("hold_fail4_v%0d", i), int'(f4), tbl[i].fl);
    end

    // Reset in the second SEARCH cycle aborts the run
    kick(1'b1, 1'b0, 16'h0081, 4'd1, 1, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bq[0].delete(); rq[0].delete();
    @(negedge clk);
    chk("abort_ready", int'(rdy1), 1);
    chk("abort_valid", int'(v1), 0);
    chk("abort_count", int'(c1), 0);
    chk("abort_count4", int'(c4), 0);
    @(posedge clk); #1;
    kick(1'b1, 1'b0, 16'h0081, 4'd1, 1, 0);
    wait_idle();

    // Starts during SEARCH and DONE are ignored; the one after DONE is taken
    kick(1'b1, 1'b0, 16'h0081, 4'd1, 1, 0);
    @(posedge clk); #1;
    start1 = 1'b1; sigma = 16'h0000; deg = 4'd0;
    @(posedge clk); #1;
    start1 = 1'b0;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (dn1) break;
      n++;
    end
    if (n >= 100) begin
      errors++; checks++;
      $display("FAIL wait_done: got no done expected done within 100 cycles");
    end
    start1 = 1'b1; sigma = 16'h0231; deg = 4'd2;
    push(0, 1, 16'h0231, 2, 0, 1);
    @(posedge clk); #1;
    chk("after_done_ready", int'(rdy1), 1);
    chk("after_done_fail_held", int'(f1), 0);
    @(posedge clk); #1;
    start1 = 1'b0;
    chk("accepted_ready", int'(rdy1), 0);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/chien_parallel.md
Name: chien_parallel

Overview:
- Parallel, handshaked Chien search. Evaluates an error-locator polynomial sigma(x) of degree <= T over GF(2^M) at alpha^i for i = 0..N-1, N = 2^M-1, testing P consecutive exponents per clock.
- Sits between the Berlekamp-Massey stage (supplies sigma and its degree) and the error-correction stage (consumes per-position root flags).
- Generalises the single-position serial search:
  - adds a P-lane datapath and a start/ready/valid handshake;
  - adds position tracking with tail masking;
  - adds root counting and a decode-failure flag.

Parameters:
- M, 4, field width; GF(2^M) with the codebase primitive polynomial (M=4: x^4+x+1).
- T, 3, maximum correctable errors; sigma has T+1 coefficients.
- P, 1, exponents evaluated per cycle; 1 <= P <= N.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- start  in  1  load request; accepted only when ready=1.
- sigma  in  M*(T+1)  coefficients; c_j at sigma[j*M+:M], c_0 at LSBs.
- deg  in  M  claimed degree of sigma (error count from BM).
- ready  out  1  idle; can accept start.
- err_valid  out  1  err/pos valid this cycle.
- err  out  P  err[l]=1 iff sigma(alpha^(pos+l))=0 and pos+l < N.
- pos  out  M  exponent evaluated by lane 0.
- done  out  1  one-cycle pulse; count/fail valid.
- count  out  M  number of roots found.
- fail  out  1  count != deg_latched.

Behaviour:
- Reset (synchronous, any state, including mid-search): state=IDLE, all term registers and counters 0. Output reset values: ready=1, err_valid=0, err=0, pos=0, done=0, count=0, fail=0.
- States: IDLE, SEARCH, DONE.
  - IDLE and start=1: load term register r_j <= c_j for all j; latch deg; pos <= 0; root accumulator <= 0; go to SEARCH. ready falls the next cycle.
  - SEARCH, every cycle:
    - err_valid=1.
    - Lane l value = XOR over j of r_j*alpha^(j*l); err[l] = (value==0) AND (pos+l < N).
    - Update r_j <= r_j*alpha^(j*P); pos <= pos+P; accumulator += popcount(err).
    - When pos+P >= N (last cycle), go to DONE.
  - DONE: single cycle. done=1; count = final accumulator; fail = (count != deg_latched); ready=1 again; go to IDLE.
- Outputs hold after DONE: count and fail keep their values until the next accepted start. err/pos hold their last value but are meaningful only while err_valid=1.
- Latency: start accepted in cycle 0 -> err_valid cycles 1..ceil(N/P) -> done in cycle ceil(N/P)+1.
- start while ready=0 is ignored; there is no queueing.
- Arithmetic:
  - All multiplies are by constants (GF constant multipliers); there are no general multipliers.
  - The accumulator is M bits wide and holds at most N = 2^M-1, so it cannot overflow.
  - pos increments by P with no modulo.
  - The tail mask covers N not divisible by P; masked lanes never count.
- Degenerate sigma:
  - All-zero sigma: every position is a root, count=N.
  - c_0 != 0 with all other c_j=0: no roots.
  - Both cases are valid inputs.
- pos exposes the evaluation exponent only. Mapping the exponent to a codeword bit index is the consumer's job.

Decomposition:
- Shared header bch.vh already provides lpow(M,k) and the GF constants. Add a helper for N = 2^M-1 and for ceil(N/P) cycles.
- Sub-module chien_term:
  - One per j.
  - Holds r_j and multiplies it by lpow(M, j*P) on advance.
  - Exposes P lane products r_j*alpha^(j*l) via parallel_standard_multiplier instances.
- Top level holds the FSM, pos counter, lane XOR reduction, tail mask, popcount, and compare.

Test Plan:
1. M=4,T=3,P=1, sigma c0=1, c1=alpha^3 (4'b1000), others 0, deg=1 -> single err at pos=12; done in cycle 16; count=1, fail=0.
2. Same sigma with P=4 -> 4 err_valid cycles with pos=0,4,8,12; err=4'b0001 only at pos=12; lane 3 of the last cycle (exponent 15) masked; count=1, fail=0.
3. Same sigma with deg=2 -> count=1, fail=1.
4. sigma all zero, deg=0, P=4 -> err=4'b1111,4'b1111,4'b1111,4'b0111; count=15, fail=1.
5. Assert reset during the 2nd SEARCH cycle -> next cycle ready=1, err_valid=0, count=0. A fresh start then reproduces scenario 1 results.
6. Pulse start during SEARCH and during DONE -> ignored; the running result is unchanged. A start in the cycle after done is accepted.
